// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with a word-serial line fill from backing memory.
// A hit answers in the same cycle. A miss stalls the fetch stage until the whole line has been fetched.
module instr_cache #(
    parameter int LINES       = 16,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        flush_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic [15:0] miss_cnt_o
);

    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 30 - WORD_W - IDX_W;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD_W-1:0]  r_cnt;
    logic [IDX_W-1:0]   r_miss_idx;
    logic [TAG_W-1:0]   r_miss_tag;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES*BLOCK_WORDS];
    logic               r_flush_pending;
    logic [15:0]        r_miss_cnt;

    logic [WORD_W-1:0]  w_word;
    logic [IDX_W-1:0]   w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_miss;
    logic               w_start_fill;
    logic               w_fill_done;
    logic               w_unused;

    // The two byte-offset bits do not take part in a word fetch.
    assign w_unused   = ^addr_i[1:0];
    assign miss_cnt_o = r_miss_cnt;

    // Address decode, hit detection and the same-cycle read port.
    always_comb begin
        w_word  = addr_i[2 +: WORD_W];
        w_index = addr_i[2 + WORD_W +: IDX_W];
        w_tag   = addr_i[31 -: TAG_W];
        w_hit   = req_i && (r_state == S_IDLE) && r_valid[w_index]
                  && (r_tag[w_index] == w_tag);
        w_miss  = req_i && !w_hit;
        if (w_hit) begin
            ready_o = 1'b1;
            data_o  = r_data[{w_index, w_word}];
        end else begin
            ready_o = 1'b0;
            data_o  = 32'd0;
        end
    end

    // FSM next state and the memory-side / stall outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_fill = 1'b0;
        w_fill_done  = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = 32'd0;
        stall_o      = w_miss;
        case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    w_state_nxt  = S_FILL;
                    w_start_fill = 1'b1;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {r_miss_tag, r_miss_idx, r_cnt, 2'b00};
                stall_o    = 1'b1;
                if (mem_ack_i && (r_cnt == LAST_WORD)) begin
                    w_state_nxt = S_IDLE;
                    w_fill_done = 1'b1;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Miss capture, word counter, valid bits, deferred flush and miss counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= {WORD_W{1'b0}};
            r_miss_idx      <= {IDX_W{1'b0}};
            r_miss_tag      <= {TAG_W{1'b0}};
            r_valid         <= {LINES{1'b0}};
            r_flush_pending <= 1'b0;
            r_miss_cnt      <= 16'd0;
        end else if (r_state == S_IDLE) begin
            if (flush_i) begin
                r_valid <= {LINES{1'b0}};
            end
            if (w_start_fill) begin
                r_miss_idx <= w_index;
                r_miss_tag <= w_tag;
                if (r_miss_cnt != 16'hFFFF) begin
                    r_miss_cnt <= r_miss_cnt + 16'd1;
                end
            end
        end else begin
            // A flush seen during the fill also kills the line being filled.
            if (w_fill_done) begin
                r_flush_pending <= 1'b0;
                if (r_flush_pending || flush_i) begin
                    r_valid <= {LINES{1'b0}};
                end else begin
                    r_valid[r_miss_idx] <= 1'b1;
                end
            end else if (flush_i) begin
                r_flush_pending <= 1'b1;
            end
            if (mem_ack_i) begin
                r_cnt <= w_fill_done ? {WORD_W{1'b0}} : r_cnt + WORD_W'(1);
            end
        end
    end

    // Data and tag arrays carry no reset; the valid bits alone qualify a hit.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_FILL) && mem_ack_i) begin
            r_data[{r_miss_idx, r_cnt}] <= mem_data_i;
            if (r_cnt == LAST_WORD) begin
                r_tag[r_miss_idx] <= r_miss_tag;
            end
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Randomized bench for instr_cache: a line-level reference model predicts hits, fill addresses, stalls and the miss count.
module tb_instr_cache;
    localparam int LINES = 16;
    localparam int BW    = 4;
    localparam int WB    = $clog2(BW);
    localparam int IB    = $clog2(LINES);

    logic        clk = 1'b0;
    logic        rst, req_i, flush_i, mem_ack_i;
    logic [31:0] addr_i, mem_data_i, data_o, mem_addr_o;
    logic        ready_o, stall_o, mem_req_o;
    logic [15:0] miss_cnt_o;

    int checks = 0;
    int errors = 0;

    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    int          m_miss;

    always #5 clk = ~clk;

    instr_cache #(.LINES(LINES), .BLOCK_WORDS(BW)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .flush_i(flush_i),
        .data_o(data_o), .ready_o(ready_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .miss_cnt_o(miss_cnt_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w >= 32'h40 && w <= 32'h4C) return 32'h11 * ((w - 32'h40) / 32'd4 + 32'd1);
        return (w * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    assign mem_data_i = mem_word(mem_addr_o);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b1; addr_i = 32'd0;
        next_cycle();
        rst = 1'b0; mem_ack_i = 1'b0;
        #1;
        check_eq("rst_mem_req", mem_req_o, 1'b0);
        check_eq("rst_ready",   ready_o,   1'b0);
        check_eq("rst_stall",   stall_o,   1'b0);
        check_eq("rst_miss_cnt", miss_cnt_o, 16'd0);
        model_clear();
        m_miss = 0;
        next_cycle();
    endtask

    // One fetch of address a, starting in an IDLE cycle and returning at the start of the following IDLE cycle.
    task automatic fetch(input logic [31:0] a, input int waits, input int flush_word, input bit flush_now);
        int unsigned idx, tg;
        bit          hit, fl;
        int          stalls;
        logic [31:0] base;
        idx  = (a >> (2 + WB)) % LINES;
        tg   = a >> (2 + WB + IB);
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        base = a & ~(32'(BW * 4) - 32'd1);
        req_i = 1'b1; addr_i = a; flush_i = flush_now; mem_ack_i = 1'($urandom % 2);
        #1;
        if (hit) begin
            check_eq("hit_ready", ready_o, 1'b1);
            check_eq("hit_data",  data_o,  mem_word(a));
            check_eq("hit_stall", stall_o, 1'b0);
            check_eq("hit_mreq",  mem_req_o, 1'b0);
            check_eq("hit_maddr", mem_addr_o, 32'd0);
            next_cycle();
            if (flush_now) model_clear();
        end else begin
            check_eq("miss_stall", stall_o, 1'b1);
            check_eq("miss_ready", ready_o, 1'b0);
            check_eq("miss_data",  data_o,  32'd0);
            check_eq("miss_mreq",  mem_req_o, 1'b0);
            stalls = 1;
            fl = 1'b0;
            next_cycle();
            if (flush_now) model_clear();
            if (m_miss < 65535) m_miss++;
            check_eq("miss_cnt", miss_cnt_o, 32'(m_miss));
            for (int w = 0; w < BW; w++) begin
                for (int d = 0; d <= waits; d++) begin
                    mem_ack_i = (d == waits);
                    flush_i   = (w == flush_word) && (d == 0);
                    req_i     = 1'($urandom % 2);
                    addr_i    = $urandom;
                    #1;
                    check_eq("fill_mreq",  mem_req_o,  1'b1);
                    check_eq("fill_maddr", mem_addr_o, base + 32'(w * 4));
                    check_eq("fill_ready", ready_o,    1'b0);
                    if (stall_o) stalls++;
                    if (flush_i) fl = 1'b1;
                    next_cycle();
                end
            end
            check_eq("stall_cycles", 32'(stalls), 32'(1 + BW * (waits + 1)));
            if (fl) begin
                model_clear();
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end
        flush_i = 1'b0; mem_ack_i = 1'b0; req_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        rst = 1'b1; req_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0; addr_i = 32'd0;

        // Cold miss, then neighbour hit, then conflict misses.
        do_reset();
        fetch(32'h40, 0, -1, 1'b0);
        fetch(32'h40, 0, -1, 1'b0);
        fetch(32'h44, 0, -1, 1'b0);
        check_eq("cold_cnt", miss_cnt_o, 16'd1);
        fetch(32'h140, 0, -1, 1'b0);
        fetch(32'h140, 0, -1, 1'b0);
        fetch(32'h40, 0, -1, 1'b0);
        fetch(32'h48, 0, -1, 1'b0);
        check_eq("conflict_cnt", miss_cnt_o, 16'd3);

        // Flush in IDLE.
        req_i = 1'b0; flush_i = 1'b1; mem_ack_i = 1'b1;
        next_cycle();
        flush_i = 1'b0; mem_ack_i = 1'b0;
        model_clear();
        fetch(32'h40, 0, -1, 1'b0);
        check_eq("iflush_cnt", miss_cnt_o, 16'd4);

        // Wait states: two idle cycles before every word.
        do_reset();
        fetch(32'h80, 2, -1, 1'b0);
        fetch(32'h8C, 0, -1, 1'b0);

        // Flush during the fill.
        do_reset();
        fetch(32'h40, 0, 2, 1'b0);
        fetch(32'h40, 0, -1, 1'b0);
        check_eq("mflush_cnt", miss_cnt_o, 16'd2);
        fetch(32'h40, 0, -1, 1'b0);

        // Reset during word 1 aborts the fill, which restarts at word 0.
        do_reset();
        req_i = 1'b1; addr_i = 32'h40; #1;
        check_eq("rmf_miss", stall_o, 1'b1);
        next_cycle();
        mem_ack_i = 1'b1; #1;
        check_eq("rmf_w0", mem_addr_o, 32'h40);
        next_cycle();
        check_eq("rmf_w1", mem_addr_o, 32'h44);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; req_i = 1'b0; mem_ack_i = 1'b0; #1;
        check_eq("rmf_mreq",  mem_req_o,  1'b0);
        check_eq("rmf_stall", stall_o,    1'b0);
        check_eq("rmf_cnt",   miss_cnt_o, 16'd0);
        model_clear();
        m_miss = 0;
        next_cycle();
        fetch(32'h40, 0, -1, 1'b0);
        fetch(32'h4C, 0, -1, 1'b0);

        // Randomized mix of hits, conflicts, wait states, flushes and idle cycles.
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                req_i = 1'b0; flush_i = 1'($urandom % 2); mem_ack_i = 1'($urandom % 2); addr_i = $urandom;
                #1;
                check_eq("idle_stall", stall_o,    1'b0);
                check_eq("idle_ready", ready_o,    1'b0);
                check_eq("idle_data",  data_o,     32'd0);
                check_eq("idle_mreq",  mem_req_o,  1'b0);
                check_eq("idle_maddr", mem_addr_o, 32'd0);
                next_cycle();
                if (flush_i) model_clear();
                flush_i = 1'b0;
            end else begin
                a = (32'($urandom_range(0, 3)) << (2 + WB + IB))
                  | (32'($urandom_range(0, LINES - 1)) << (2 + WB))
                  | ($urandom & 32'(BW * 4 - 1));
                fetch(a, $urandom_range(0, 2),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BW - 1)) : -1,
                      ($urandom_range(0, 7) == 0));
            end
        end
        check_eq("final_cnt", miss_cnt_o, 32'(m_miss));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter BLOCK_WORDS, default 4, 32-bit words per line (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_i  input  1  fetch request from the program counter.
REQ-006 SHALL have port addr_i  input  32  byte fetch address.
REQ-007 SHALL have port flush_i  input  1  invalidate all lines.
REQ-008 SHALL have port data_o  output  32  fetched instruction.
REQ-009 SHALL have port ready_o  output  1  data_o valid this cycle.
REQ-010 SHALL have port stall_o  output  1  hold PC and the IF/ID latch.
REQ-011 SHALL have port mem_req_o  output  1  backing-memory word read request.
REQ-012 SHALL have port mem_addr_o  output  32  backing-memory byte address.
REQ-013 SHALL have port mem_data_i  input  32  backing-memory read data.
REQ-014 SHALL have port mem_ack_i  input  1  mem_data_i valid; word accepted.
REQ-015 SHALL have port miss_cnt_o  output  16  miss counter.

Function
REQ-016 SHALL decode addr_i as follows (defaults): [1:0] ignored, [3:2] word, [7:4] index, [31:8] tag; field widths scale with the parameters.
REQ-017 SHALL define hit as req_i & state IDLE & valid[index] & tag match; on hit, ready_o=1, stall_o=0, and data_o=the addressed word, all combinational in the same cycle.
REQ-018 SHALL drive ready_o=0 and data_o=0 whenever a hit is not present.
REQ-019 SHALL define miss as req_i & ~hit; stall_o SHALL be 1 combinationally on miss and in every FILL cycle, and 0 otherwise.
REQ-020 SHALL implement the FSM states IDLE and FILL; IDLE goes to FILL on the edge where a miss is present and captures tag/index into a miss register at that edge.
REQ-021 SHALL hold mem_req_o=1 for the whole FILL state, with mem_addr_o={miss tag, miss index, word counter, 2'b00}; the word counter starts at 0.
REQ-022 SHALL, on each FILL edge with mem_ack_i=1, write mem_data_i into line[index][counter] and increment the counter; with mem_ack_i=0, mem_addr_o SHALL stay unchanged.
REQ-023 SHALL, on the ack edge of the last word, write the tag, set valid, reset the counter to 0, and go to IDLE; the retried fetch then hits in the following cycle.
REQ-024 SHALL give a miss penalty of BLOCK_WORDS+1 cycles (miss cycle to hit cycle) with zero-wait memory.
REQ-025 SHALL ignore addr_i and req_i changes during FILL; the fill always completes for the captured address.
REQ-026 SHALL drive mem_req_o=0 and mem_addr_o=0 in IDLE; mem_ack_i in IDLE SHALL be ignored.
REQ-027 SHALL, for flush_i in IDLE, clear all valid bits at that edge; a miss in the same cycle SHALL still start FILL.
REQ-028 SHALL, for flush_i during FILL, set flush_pending; on the final fill edge, all valid bits including the filled line SHALL be cleared and flush_pending SHALL be cleared.
REQ-029 SHALL increment miss_cnt_o once per IDLE->FILL transition, saturating at 0xFFFF.
REQ-030 SHALL leave data-array contents undefined until first fill; valid bits alone SHALL gate hits.

Reset
REQ-031 SHALL, when rst=1 at an edge, set state=IDLE, counter=0, all valid=0, flush_pending=0, and miss_cnt_o=0, aborting any fill.
REQ-032 SHALL drive mem_req_o=0, ready_o=0, and stall_o=0 in the first cycle after reset (with req_i low).
REQ-033 SHALL give rst priority over flush_i, miss detection, and mem_ack_i.

Verification
REQ-034 SHALL verify cold miss: after reset, req 0x40 with ack held high and memory words 0x11,0x22,0x33,0x44 -> mem_addr_o 0x40/0x44/0x48/0x4C in cycles 1-4, ready_o=1 with data_o=0x11 in cycle 5, then req 0x44 hits immediately with 0x22, and miss_cnt_o=1.
REQ-035 SHALL verify conflict: after 0x40 is filled, req 0x140 (index 4, tag 1) misses and refills, then req 0x40 misses again -> miss_cnt_o=3.
REQ-036 SHALL verify wait states: mem_ack_i low for 2 cycles before each word -> mem_addr_o holds, stall_o=1 for 13 cycles total, and data is correct.
REQ-037 SHALL verify flush in IDLE: with 0x40 cached, pulse flush_i -> next req 0x40 misses and mem_req_o rises.
REQ-038 SHALL verify flush mid-fill: flush_i at word 2 -> fill completes to word 3, the line is invalid, and the stalled req 0x40 misses again with miss_cnt_o=2.
REQ-039 SHALL verify reset mid-fill: rst during word 1 -> mem_req_o=0 the next cycle, and req 0x40 misses with fill restarting at word 0.
